// File: rtl/cp0_irq_ctrl_pkg.sv
// Shared definitions for the coprocessor-0 interrupt controller:
// register numbers, bit positions, exception codes and the read default.
package cp0_pkg;

    // CP0 register numbers used by MFC0/MTC0.
    localparam logic [4:0] CP0_COUNT   = 5'd9;
    localparam logic [4:0] CP0_COMPARE = 5'd11;
    localparam logic [4:0] CP0_STATUS  = 5'd12;
    localparam logic [4:0] CP0_CAUSE   = 5'd13;
    localparam logic [4:0] CP0_EPC     = 5'd14;
    localparam logic [4:0] CP0_PRID    = 5'd15;

    // Bit positions inside Status and Cause.
    localparam int IE      = 0;
    localparam int EXL     = 1;
    localparam int EXC_LSB = 2;
    localparam int IP_LSB  = 10;

    // Width of the architectural IM/IP field (bits 15:10).
    localparam int IP_MAX = 6;

    // Exception code meaning "external or timer interrupt".
    localparam logic [4:0] EXC_INT = 5'd0;

    // Value returned for any register number that is not decoded.
    localparam logic [31:0] READ_DEFAULT = 32'hDEADBEEF;

    // Mask covering the lowest nch bits of the IM/IP field.
    function automatic logic [31:0] ip_field_mask(input int nch);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < IP_MAX; i++) begin
            if (i < nch) m[IP_LSB + i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/cp0_irq_ctrl_if.sv
// Bus between the multi-cycle core and CP0: MFC0/MTC0 access, handler
// entry/exit strobes, external interrupt lines and the interrupt request.
interface cp0_irq_ctrl_if #(
    parameter int N_INT = 5
);
    logic [4:0]       reg_sel;
    logic [31:0]      reg_in;
    logic             reg_we;
    logic [31:0]      reg_out;
    logic [31:0]      epc_in;
    logic [31:0]      epc_out;
    logic             isr_enter;
    logic [4:0]       exc_code;
    logic             isr_leave;
    logic [N_INT-1:0] ext_int;
    logic             irq;
    logic [2:0]       irq_id;

    // Core / controller side.
    modport master (
        output reg_sel, reg_in, reg_we, epc_in, isr_enter, exc_code,
               isr_leave, ext_int,
        input  reg_out, epc_out, irq, irq_id
    );

    // CP0 side.
    modport slave (
        input  reg_sel, reg_in, reg_we, epc_in, isr_enter, exc_code,
               isr_leave, ext_int,
        output reg_out, epc_out, irq, irq_id
    );
endinterface

// File: rtl/cp0_irq_ctrl_prio_enc.sv
// Lowest-index-wins priority encoder over the pending interrupt channels.
// Produces a valid flag, the binary index and the one-hot of the winner.
module cp0_prio_enc #(
    parameter int W = 6
) (
    input  logic [W-1:0] pend,
    output logic         valid,
    output logic [2:0]   id,
    output logic [W-1:0] onehot
);

    // Scan from the top down so the lowest set index is the last to be taken.
    always_comb begin
        id = 3'd0;
        for (int i = W - 1; i >= 0; i--) begin
            if (pend[i]) id = 3'(i);
        end
    end

    assign valid  = |pend;
    assign onehot = pend & (~pend + W'(1));

endmodule

// File: rtl/cp0_irq_ctrl.sv
// Coprocessor-0 register block with configurable external interrupt lines
// and an optional Count/Compare timer on channel N_INT.
module cp0_irq_ctrl
    import cp0_pkg::*;
#(
    parameter int          N_INT    = 5,
    parameter int          TIMER_EN = 1,
    parameter logic [31:0] PRID     = 32'h0996FACE
) (
    input logic           clk,
    input logic           rst,
    cp0_irq_ctrl_if.slave bus
);

    localparam int NCH = N_INT + TIMER_EN;

    // External channels are the low N_INT bits; the timer (if any) is above.
    localparam logic [NCH-1:0] EXT_MASK   = NCH'((1 << N_INT) - 1);
    localparam logic [NCH-1:0] TIMER_MASK = ~EXT_MASK;

    // IM bits with no channel behind them always hold 0.
    localparam logic [31:0] IM_UNUSED = ip_field_mask(IP_MAX) & ~ip_field_mask(NCH);

    logic [31:0]    status_q, status_d;
    logic [31:0]    epc_q, epc_d;
    logic [31:0]    count_q, count_d;
    logic [31:0]    compare_q, compare_d;
    logic [4:0]     exc_q, exc_d;
    logic [NCH-1:0] ip_q, ip_d;
    logic [NCH-1:0] svc_q, svc_d;

    logic [NCH-1:0] im;
    logic [NCH-1:0] pend;
    logic [NCH-1:0] pend_onehot;
    logic           pend_valid;
    logic [2:0]     pend_id;
    logic           irq_int;

    logic [NCH-1:0] ip_set;
    logic [NCH-1:0] ip_clr;
    logic           timer_match;

    logic wr_status;
    logic wr_epc;
    logic wr_count;
    logic wr_compare;

    logic [31:0] cause_word;

    assign wr_status  = bus.reg_we && (bus.reg_sel == CP0_STATUS);
    assign wr_epc     = bus.reg_we && (bus.reg_sel == CP0_EPC);
    assign wr_count   = bus.reg_we && (bus.reg_sel == CP0_COUNT)   && (TIMER_EN != 0);
    assign wr_compare = bus.reg_we && (bus.reg_sel == CP0_COMPARE) && (TIMER_EN != 0);

    assign im   = status_q[IP_LSB +: NCH];
    assign pend = ip_q & im;

    cp0_prio_enc #(
        .W (NCH)
    ) u_prio (
        .pend   (pend),
        .valid  (pend_valid),
        .id     (pend_id),
        .onehot (pend_onehot)
    );

    assign irq_int     = status_q[IE] & ~status_q[EXL] & pend_valid;
    assign bus.irq     = irq_int;
    assign bus.irq_id  = irq_int ? pend_id : 3'd0;
    assign bus.epc_out = epc_q;

    assign timer_match = (count_q == compare_q);

    // Status: software owns every bit except EXL, which only handler entry/exit moves.
    always_comb begin
        status_d = status_q;
        if (wr_status) begin
            status_d      = bus.reg_in & ~IM_UNUSED;
            status_d[EXL] = status_q[EXL];
        end
        if (bus.isr_enter) begin
            status_d[EXL] = 1'b1;
        end else if (bus.isr_leave) begin
            status_d[EXL] = 1'b0;
        end
    end

    // EPC, ExcCode and the serviced-channel latch, all captured at handler entry.
    always_comb begin
        epc_d = epc_q;
        exc_d = exc_q;
        svc_d = svc_q;
        if (bus.isr_enter) begin
            epc_d = bus.epc_in;
            exc_d = bus.exc_code;
            if (bus.exc_code == EXC_INT) begin
                svc_d = irq_int ? pend_onehot : '0;
            end else begin
                svc_d = '0;
            end
        end else if (wr_epc) begin
            epc_d = bus.reg_in;
        end
    end

    // Count/Compare timer; both registers stay at zero when the timer is absent.
    always_comb begin
        count_d   = '0;
        compare_d = '0;
        if (TIMER_EN != 0) begin
            count_d   = wr_count   ? bus.reg_in : count_q + 32'd1;
            compare_d = wr_compare ? bus.reg_in : compare_q;
        end
    end

    // Sticky pending bits: set by lines or timer match, clear always beats set.
    always_comb begin
        ip_set              = '0;
        ip_set[N_INT-1:0]   = bus.ext_int;
        if (TIMER_EN != 0) begin
            ip_set[NCH-1] = timer_match;
        end
        ip_clr = (bus.isr_leave ? (svc_q & EXT_MASK) : '0)
               | (wr_compare    ? TIMER_MASK         : '0);
        ip_d   = (ip_q | ip_set) & ~ip_clr;
    end

    // Architectural state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            status_q  <= '0;
            epc_q     <= '0;
            count_q   <= '0;
            compare_q <= '0;
            exc_q     <= '0;
            ip_q      <= '0;
            svc_q     <= '0;
        end else begin
            status_q  <= status_d;
            epc_q     <= epc_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            exc_q     <= exc_d;
            ip_q      <= ip_d;
            svc_q     <= svc_d;
        end
    end

    // Assemble Cause from the pending bits and the latched exception code.
    always_comb begin
        cause_word                  = '0;
        cause_word[IP_LSB +: NCH]   = ip_q;
        cause_word[EXC_LSB +: 5]    = exc_q;
    end

    // MFC0 read mux, combinational on the register number.
    always_comb begin
        bus.reg_out = READ_DEFAULT;
        case (bus.reg_sel)
            CP0_COUNT:   bus.reg_out = count_q;
            CP0_COMPARE: bus.reg_out = compare_q;
            CP0_STATUS:  bus.reg_out = status_q;
            CP0_CAUSE:   bus.reg_out = cause_word;
            CP0_EPC:     bus.reg_out = epc_q;
            CP0_PRID:    bus.reg_out = PRID;
            default:     bus.reg_out = READ_DEFAULT;
        endcase
    end

endmodule

// File: tb/tb_cp0_irq_ctrl.sv
// Directed testbench for cp0_irq_ctrl: a vector table for the single-step
// behaviour plus hand-written sequences for timer, collisions, wrap and reset.
module tb_cp0_irq_ctrl;
    import cp0_pkg::*;

    typedef struct {
        logic [4:0]  sel;
        logic [31:0] din;
        logic        we;
        logic        enter;
        logic [4:0]  code;
        logic        leave;
        logic [31:0] epc;
        logic [4:0]  ext;
        logic [4:0]  rsel;
        logic [31:0] exp_rd;
        logic        exp_irq;
        logic [2:0]  exp_id;
        logic [31:0] exp_epc;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    vec_t vecs[13];
    logic [31:0] rd;

    cp0_irq_ctrl_if #(.N_INT(5)) bus ();

    cp0_irq_ctrl #(
        .N_INT    (5),
        .TIMER_EN (1),
        .PRID     (32'h0996FACE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Safety net so the run always terminates.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired before the test finished");
        $fatal(1, "[TB] watchdog");
    end

    function automatic vec_t mk(input logic [4:0] sel, input logic [31:0] din,
                                input logic we, input logic enter,
                                input logic [4:0] code, input logic leave,
                                input logic [31:0] epc, input logic [4:0] ext,
                                input logic [4:0] rsel, input logic [31:0] exp_rd,
                                input logic exp_irq, input logic [2:0] exp_id,
                                input logic [31:0] exp_epc);
        vec_t v;
        v.sel = sel; v.din = din; v.we = we; v.enter = enter; v.code = code;
        v.leave = leave; v.epc = epc; v.ext = ext; v.rsel = rsel;
        v.exp_rd = exp_rd; v.exp_irq = exp_irq; v.exp_id = exp_id;
        v.exp_epc = exp_epc;
        return v;
    endfunction

    task automatic driveIdle();
        bus.reg_we    = 1'b0;
        bus.reg_in    = '0;
        bus.isr_enter = 1'b0;
        bus.isr_leave = 1'b0;
        bus.exc_code  = '0;
        bus.epc_in    = '0;
        bus.ext_int   = '0;
    endtask

    // Drive one vector across a single rising edge, then return the bus to idle.
    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        bus.reg_sel   = v.sel;
        bus.reg_in    = v.din;
        bus.reg_we    = v.we;
        bus.isr_enter = v.enter;
        bus.exc_code  = v.code;
        bus.isr_leave = v.leave;
        bus.epc_in    = v.epc;
        bus.ext_int   = v.ext;
        @(posedge clk);
        #1;
        driveIdle();
        bus.reg_sel = v.rsel;
        #1;
    endtask

    task automatic idleCycle();
        applyStimulus(mk(5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 32'h0, 5'b0,
                         5'd0, 32'h0, 1'b0, 3'd0, 32'h0));
    endtask

    task automatic readReg(input logic [4:0] sel, output logic [31:0] val);
        bus.reg_sel = sel;
        #1;
        val = bus.reg_out;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] got,
                               input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic checkVector(input int idx, input vec_t v);
        checkOutput($sformatf("vec%0d read", idx), bus.reg_out, v.exp_rd);
        checkOutput($sformatf("vec%0d irq", idx), 32'(bus.irq), 32'(v.exp_irq));
        checkOutput($sformatf("vec%0d irq_id", idx), 32'(bus.irq_id), 32'(v.exp_id));
        checkOutput($sformatf("vec%0d epc_out", idx), bus.epc_out, v.exp_epc);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        bus.reg_sel = '0;
        driveIdle();

        //             sel   din            we    ent   code  lv    epc_in       ext       rsel  exp_rd        irq   id    epc
        vecs[0]  = mk(5'd11, 32'h8000_0000, 1'b1, 1'b0, 5'd0, 1'b0, 32'h0,      5'b00000, 5'd13, 32'h0000_0000, 1'b0, 3'd0, 32'h0);
        vecs[1]  = mk(5'd12, 32'h0000_7C01, 1'b1, 1'b0, 5'd0, 1'b0, 32'h0,      5'b00000, 5'd12, 32'h0000_7C01, 1'b0, 3'd0, 32'h0);
        vecs[2]  = mk(5'd0,  32'h0,         1'b0, 1'b0, 5'd0, 1'b0, 32'h0,      5'b10100, 5'd13, 32'h0000_5000, 1'b1, 3'd2, 32'h0);
        vecs[3]  = mk(5'd0,  32'h0,         1'b0, 1'b1, 5'd0, 1'b0, 32'h3008,   5'b00000, 5'd12, 32'h0000_7C03, 1'b0, 3'd0, 32'h3008);
        vecs[4]  = mk(5'd0,  32'h0,         1'b0, 1'b0, 5'd0, 1'b1, 32'h0,      5'b00000, 5'd13, 32'h0000_4000, 1'b1, 3'd4, 32'h3008);
        vecs[5]  = mk(5'd0,  32'h0,         1'b0, 1'b0, 5'd0, 1'b0, 32'h0,      5'b00000, 5'd12, 32'h0000_7C01, 1'b1, 3'd4, 32'h3008);
        vecs[6]  = mk(5'd0,  32'h0,         1'b0, 1'b1, 5'd12, 1'b0, 32'h5000,  5'b00000, 5'd13, 32'h0000_4030, 1'b0, 3'd0, 32'h5000);
        vecs[7]  = mk(5'd0,  32'h0,         1'b0, 1'b0, 5'd0, 1'b1, 32'h0,      5'b00000, 5'd13, 32'h0000_4030, 1'b1, 3'd4, 32'h5000);
        vecs[8]  = mk(5'd0,  32'h0,         1'b0, 1'b1, 5'd0, 1'b0, 32'h6000,   5'b00000, 5'd12, 32'h0000_7C03, 1'b0, 3'd0, 32'h6000);
        vecs[9]  = mk(5'd0,  32'h0,         1'b0, 1'b0, 5'd0, 1'b1, 32'h0,      5'b00000, 5'd13, 32'h0000_0000, 1'b0, 3'd0, 32'h6000);
        vecs[10] = mk(5'd9,  32'd10,        1'b1, 1'b0, 5'd0, 1'b0, 32'h0,      5'b00000, 5'd9,  32'd10,        1'b0, 3'd0, 32'h6000);
        vecs[11] = mk(5'd11, 32'd20,        1'b1, 1'b0, 5'd0, 1'b0, 32'h0,      5'b00000, 5'd9,  32'd11,        1'b0, 3'd0, 32'h6000);
        vecs[12] = mk(5'd12, 32'h0000_FC01, 1'b1, 1'b0, 5'd0, 1'b0, 32'h0,      5'b00000, 5'd12, 32'h0000_FC01, 1'b0, 3'd0, 32'h6000);

        // Reset state.
        @(posedge clk);
        #1;
        readReg(CP0_STATUS, rd);  checkOutput("reset status", rd, 32'h0);
        readReg(CP0_CAUSE, rd);   checkOutput("reset cause", rd, 32'h0);
        readReg(CP0_EPC, rd);     checkOutput("reset epc", rd, 32'h0);
        readReg(CP0_COUNT, rd);   checkOutput("reset count", rd, 32'h0);
        readReg(CP0_COMPARE, rd); checkOutput("reset compare", rd, 32'h0);
        readReg(CP0_PRID, rd);    checkOutput("reset prid", rd, 32'h0996FACE);
        checkOutput("reset irq", 32'(bus.irq), 32'h0);
        checkOutput("reset irq_id", 32'(bus.irq_id), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Table: priority/clear, exception path, timer setup.
        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i]);
            checkVector(i, vecs[i]);
        end

        // Timer: Count was written 2 edges ago; match lands on edge 10, IP5 on edge 11.
        for (int i = 0; i < 8; i++) idleCycle();
        readReg(CP0_COUNT, rd); checkOutput("timer count at match", rd, 32'd20);
        readReg(CP0_CAUSE, rd); checkOutput("timer ip before set", rd, 32'h0);
        checkOutput("timer irq before set", 32'(bus.irq), 32'h0);
        idleCycle();
        readReg(CP0_CAUSE, rd); checkOutput("timer ip set", rd, 32'h0000_8000);
        checkOutput("timer irq", 32'(bus.irq), 32'h1);
        checkOutput("timer irq_id", 32'(bus.irq_id), 32'd5);
        applyStimulus(mk(5'd11, 32'd50, 1'b1, 1'b0, 5'd0, 1'b0, 32'h0, 5'b0,
                         5'd13, 32'h0, 1'b0, 3'd0, 32'h0));
        checkOutput("compare write clears ip5", bus.reg_out, 32'h0);
        checkOutput("irq after compare write", 32'(bus.irq), 32'h0);
        readReg(CP0_COMPARE, rd); checkOutput("compare readback", rd, 32'd50);

        // Collisions.
        applyStimulus(mk(5'd14, 32'h1234, 1'b1, 1'b1, 5'd0, 1'b0, 32'h4000, 5'b0,
                         5'd14, 32'h0, 1'b0, 3'd0, 32'h0));
        checkOutput("epc enter beats mtc0", bus.reg_out, 32'h4000);
        readReg(CP0_STATUS, rd); checkOutput("exl set on enter", rd, 32'h0000_FC03);
        applyStimulus(mk(5'd12, 32'h0000_FC01, 1'b1, 1'b0, 5'd0, 1'b0, 32'h0, 5'b0,
                         5'd12, 32'h0, 1'b0, 3'd0, 32'h0));
        checkOutput("mtc0 cannot clear exl", bus.reg_out, 32'h0000_FC03);
        applyStimulus(mk(5'd0, 32'h0, 1'b0, 1'b1, 5'd0, 1'b1, 32'h4100, 5'b0,
                         5'd12, 32'h0, 1'b0, 3'd0, 32'h0));
        checkOutput("enter beats leave", bus.reg_out, 32'h0000_FC03);
        checkOutput("epc on enter+leave", bus.epc_out, 32'h4100);
        applyStimulus(mk(5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b1, 32'h0, 5'b0,
                         5'd12, 32'h0, 1'b0, 3'd0, 32'h0));
        checkOutput("leave clears exl", bus.reg_out, 32'h0000_FC01);
        applyStimulus(mk(5'd12, 32'h0000_FC03, 1'b1, 1'b0, 5'd0, 1'b0, 32'h0, 5'b0,
                         5'd12, 32'h0, 1'b0, 3'd0, 32'h0));
        checkOutput("mtc0 cannot set exl", bus.reg_out, 32'h0000_FC01);

        // Count wrap.
        applyStimulus(mk(5'd9, 32'hFFFF_FFFF, 1'b1, 1'b0, 5'd0, 1'b0, 32'h0, 5'b0,
                         5'd9, 32'h0, 1'b0, 3'd0, 32'h0));
        checkOutput("count loaded max", bus.reg_out, 32'hFFFF_FFFF);
        idleCycle();
        readReg(CP0_COUNT, rd); checkOutput("count wraps", rd, 32'h0);

        // Undecoded register: reads default, write ignored.
        applyStimulus(mk(5'd3, 32'h1111_1111, 1'b1, 1'b0, 5'd0, 1'b0, 32'h0, 5'b0,
                         5'd3, 32'h0, 1'b0, 3'd0, 32'h0));
        checkOutput("undecoded read", bus.reg_out, 32'hDEADBEEF);
        readReg(CP0_STATUS, rd); checkOutput("status after ignored write", rd, 32'h0000_FC01);

        // Reset in the middle of a handler.
        applyStimulus(mk(5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 32'h0, 5'b00011,
                         5'd13, 32'h0, 1'b0, 3'd0, 32'h0));
        checkOutput("pre-reset cause", bus.reg_out, 32'h0000_0C00);
        checkOutput("pre-reset irq_id", 32'(bus.irq_id), 32'd0);
        applyStimulus(mk(5'd0, 32'h0, 1'b0, 1'b1, 5'd0, 1'b0, 32'h7000, 5'b0,
                         5'd12, 32'h0, 1'b0, 3'd0, 32'h0));
        checkOutput("pre-reset exl", bus.reg_out, 32'h0000_FC03);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        readReg(CP0_STATUS, rd);  checkOutput("mid reset status", rd, 32'h0);
        readReg(CP0_CAUSE, rd);   checkOutput("mid reset cause", rd, 32'h0);
        readReg(CP0_EPC, rd);     checkOutput("mid reset epc", rd, 32'h0);
        readReg(CP0_COUNT, rd);   checkOutput("mid reset count", rd, 32'h0);
        readReg(CP0_COMPARE, rd); checkOutput("mid reset compare", rd, 32'h0);
        readReg(CP0_PRID, rd);    checkOutput("mid reset prid", rd, 32'h0996FACE);
        checkOutput("mid reset irq", 32'(bus.irq), 32'h0);
        checkOutput("mid reset epc_out", bus.epc_out, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        idleCycle();
        readReg(CP0_CAUSE, rd); checkOutput("post reset cause", rd, 32'h0000_8000);
        checkOutput("post reset irq", 32'(bus.irq), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cp0_irq_ctrl.md
Name: cp0_irq_ctrl

Overview:
Parametrised coprocessor-0 block for the multi-cycle MIPS core. It holds Status, Cause, EPC, PRId, Count and Compare. Compared with the single-configuration CP0 it adds a configurable number of external interrupt lines, a Count/Compare timer that raises its own interrupt channel, exception codes latched into Cause, and the index of the highest-priority pending interrupt as an output. The controller FSM drives it through isr_enter and isr_leave, and it connects to the MFC0/MTC0 datapath.

Parameters:
- N_INT, 5, number of external interrupt lines; legal range 1..6-TIMER_EN.
- TIMER_EN, 1, 1 = Count/Compare timer present and using interrupt channel N_INT.
- PRID, 32'h0996FACE, constant value returned for $15.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- reg_sel  in  5  CP0 register number for read and write.
- reg_in  in  32  MTC0 write data.
- reg_we  in  1  MTC0 write enable.
- reg_out  out  32  MFC0 read data (combinational on reg_sel).
- epc_in  in  32  return PC captured on isr_enter.
- epc_out  out  32  current EPC.
- isr_enter  in  1  handler entry this cycle.
- exc_code  in  5  cause code for isr_enter; 0 = interrupt.
- isr_leave  in  1  ERET this cycle.
- ext_int  in  N_INT  level interrupt requests.
- irq  out  1  interrupt request to the controller.
- irq_id  out  3  highest-priority enabled pending channel; 0 when irq=0.

Behaviour:
- Interrupt field:
  - Channel count NCH = N_INT + TIMER_EN.
  - IM is Status[9+NCH:10]; IP is Cause[9+NCH:10].
  - Unused bits of both fields read 0.
- Reset: every register is cleared to 0 on the first clk edge with rst=1, except PRId. All outputs follow from the cleared state, so irq=0, irq_id=0 and epc_out=0.
- Status ($12), MTC0:
  - Writes all bits except EXL (bit1).
  - Unimplemented IM bits are forced to 0.
- Status.EXL:
  - Set on isr_enter; cleared on isr_leave.
  - If isr_enter and isr_leave occur together, enter wins.
  - An MTC0 in the same cycle still writes the other bits.
- Cause ($13): read-only to software.
  - ExcCode[6:2] is loaded with exc_code on isr_enter.
  - The IP bits of external channels are sticky:
    - next IP = (IP | ext_int) & ~clr.
    - When clear and set coincide, clear wins; a line still high is re-latched next cycle.
- Serviced channel:
  - On isr_enter with exc_code=0, the block latches svc = irq_id (one-hot).
  - On isr_enter with exc_code≠0, svc is cleared.
  - On isr_leave, clr = svc for external channels only.
- Priority: the lowest channel index wins.
  - irq_id = the lowest i with IP[i] & IM[i].
  - irq = Status.IE(bit0) & ~EXL & |(IP & IM), fully combinational.
- EPC ($14):
  - Loaded from epc_in on isr_enter.
  - Otherwise loaded by MTC0.
  - If both happen in the same cycle, isr_enter wins.
- Count ($9):
  - Increments by 1 every cycle and wraps from 0xFFFFFFFF to 0.
  - An MTC0 write loads reg_in and suppresses the increment that cycle.
- Compare ($11):
  - MTC0 writes it.
  - A write to Compare clears the timer IP bit the same edge; the clear beats a coincident set.
- Timer IP:
  - Set on the edge after the registered Count == Compare, i.e. the cycle following the match.
  - Not cleared by isr_leave.
- TIMER_EN=0:
  - $9 and $11 read 0 and ignore writes.
  - No timer channel exists.
- Read decode:
  - 9 → Count, 11 → Compare, 12 → Status, 13 → Cause, 14 → EPC, 15 → PRID.
  - Any other selection reads 32'hDEADBEEF.
- Writes to unlisted registers are ignored.
- rst asserted during a handler: EXL, svc and all IP bits clear, and no pending interrupt survives.

Decomposition:
- The shared package cp0_pkg holds:
  - Register numbers CP0_COUNT=9, CP0_COMPARE=11, CP0_STATUS=12, CP0_CAUSE=13, CP0_EPC=14, CP0_PRID=15.
  - Bit positions: IE=0, EXL=1, IP_LSB=10, EXC_LSB=2.
  - Constant EXC_INT=5'd0 and the read default 32'hDEADBEEF.
- Sub-module cp0_prio_enc (NCH-wide lowest-index priority encoder: pending vector → valid, id, one-hot) is instantiated once. It is reused for the svc capture.

Test Plan:
- Priority and clear:
  - Setup: N_INT=5, Status=32'h0000_7C01 (IM 0..4, IE); pulse ext_int=5'b10100 for 1 cycle.
  - Expect: irq=1, irq_id=2.
  - isr_enter, exc_code=0, epc_in=0x3008: EPC=0x3008, EXL=1, irq=0.
  - isr_leave: IP2 clears, IP4 remains, irq=1, irq_id=4.
- Exception path:
  - Stimulus: isr_enter with exc_code=12.
  - Expect: Cause[6:2]=12, no IP bit cleared on the following isr_leave, EXL back to 0.
- Timer:
  - Stimulus: MTC0 Compare=20, Count=10, IM bit 15 set.
  - Expect: IP5 set 11 cycles after the Count write (one cycle after Count reads 20), irq_id=5.
  - Then MTC0 Compare=50: IP5 clears the next cycle.
- Collisions:
  - isr_enter with MTC0 EPC=0x1234 and epc_in=0x4000 in the same cycle → EPC=0x4000.
  - MTC0 Status writing bit1=0 during EXL=1 → EXL stays 1.
  - isr_enter and isr_leave together → EXL=1.
- Wrap and reset:
  - Count=32'hFFFFFFFF → reads 0 next cycle.
  - rst mid-handler → all registers 0 (PRId unchanged), irq=0.
  - Read of reg_sel=3 → 32'hDEADBEEF.
